// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and glitch-filters the bus,
// deframes start/8 data/odd parity/stop and strobes rda for each good byte.
module ps2_rx #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_data,
    input  logic       ps2_clk,
    input  logic       rx_en,
    output logic       rda,
    output logic [7:0] data
);

    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        clk_sync_q, clk_sync_d;
    logic [1:0]        dat_sync_q, dat_sync_d;
    logic              filt_q, filt_d;
    logic [FLT_W-1:0]  flt_cnt_q, flt_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [7:0]        data_q, data_d;
    logic              rda_q, rda_d;
    logic              fall_c;
    logic              sample_c;

    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};

        // Filtered level flips only after FILTER_LEN consecutive samples at the new level.
        filt_d    = filt_q;
        flt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_W'(1);
            end
        end

        fall_c   = filt_q & ~filt_d;
        sample_c = dat_sync_q[1];

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        data_d    = data_q;
        rda_d     = 1'b0;

        if (state_q == IDLE || fall_c) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end

        if (!rx_en) begin
            state_d = IDLE;
            wd_d    = '0;
        end else if (state_q != IDLE && wd_q == WD_W'(TIMEOUT - 1)) begin
            // Device stalled mid-frame: drop the partial byte.
            state_d = IDLE;
            wd_d    = '0;
        end else if (fall_c) begin
            case (state_q)
                IDLE: begin
                    if (!sample_c) begin
                        state_d   = DATA;
                        shift_d   = '0;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {sample_c, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = sample_c;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (sample_c && ((^shift_q) ^ parity_q)) begin
                        data_d = shift_q;
                        rda_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            flt_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            wd_q       <= '0;
            data_q     <= '0;
            rda_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_q     <= filt_d;
            flt_cnt_q  <= flt_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            wd_q       <= wd_d;
            data_q     <= data_d;
            rda_q      <= rda_d;
        end
    end

    assign rda  = rda_q;
    assign data = data_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: drives PS/2 frames at 150 ns bit period and
// scoreboards every rda pulse against the bytes that should be received.
module tb_ps2_rx;

    localparam int unsigned FILTER_LEN = 4;
    localparam int unsigned TIMEOUT    = 20000;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_data;
    logic       ps2_clk;
    logic       rx_en;
    logic       rda;
    logic [7:0] data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int obs_rd = 0;
    int last_fall_cyc = 0;
    int idx;
    logic [7:0] exp_q[$];
    logic [7:0] obs_data[$];
    int         obs_cyc[$];

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2_data(ps2_data),
        .ps2_clk (ps2_clk),
        .rx_en   (rx_en),
        .rda     (rda),
        .data    (data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every clk cycle with rda high is logged; a stretched pulse shows up as an extra entry.
    always @(negedge clk) begin
        if (rda === 1'b1) begin
            obs_data.push_back(data);
            obs_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_bit(input logic v);
        ps2_data = v;
        #75;
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        #75;
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(stop);
        ps2_data = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back(b);
        send_frame(b, ~^b, 1'b1);
    endtask

    task automatic idle_bits(input int n);
        ps2_data = 1'b1;
        repeat (n) #150;
    endtask

    // Compare every expected byte against logged pulses, then confirm no extras.
    task automatic drain(input string tag);
        logic [7:0] e;
        repeat (FILTER_LEN + 12) @(posedge clk);
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_data.size()) begin
                check(tag, 32'(obs_data[obs_rd]), 32'(e));
                obs_rd++;
            end else begin
                check({tag, "_missing"}, 32'(obs_data.size()), 32'(obs_rd + 1));
            end
        end
        check({tag, "_count"}, 32'(obs_data.size()), 32'(obs_rd));
    endtask

    initial begin
        rst      = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rx_en    = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_rda", 32'(rda), 32'd0);
        check("reset_data", 32'(data), 32'h00);
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle_bits(1);

        // Single frame with latency bound
        idx = obs_rd;
        send_good(8'h53);
        drain("frame53");
        if (obs_cyc.size() > idx)
            check("latency53", 32'((obs_cyc[idx] - last_fall_cyc) <= int'(FILTER_LEN + 4)), 32'd1);
        check("data53", 32'(data), 32'h53);

        // Continuous stream, some with a single idle bit between
        send_good(8'h53);
        send_good(8'h04);
        idle_bits(1);
        send_good(8'h53);
        send_good(8'h04);
        idle_bits(1);
        send_good(8'h53);
        drain("stream");

        send_good(8'hA5);
        drain("frameA5");
        check("dataA5", 32'(data), 32'hA5);

        // Bad parity then bad stop: silently dropped
        send_frame(8'h53, 1'b0, 1'b1);
        drain("badpar");
        check("badpar_hold", 32'(data), 32'hA5);
        idle_bits(1);
        send_frame(8'h3C, 1'b1, 1'b0);
        drain("badstop");
        check("badstop_hold", 32'(data), 32'hA5);
        idle_bits(1);

        // Whole frame with receiver disabled, then an enabled frame
        rx_en = 1'b0;
        send_frame(8'h53, 1'b1, 1'b1);
        drain("rxen_off");
        check("rxen_off_hold", 32'(data), 32'hA5);
        rx_en = 1'b1;
        idle_bits(1);
        send_good(8'h04);
        drain("rxen_on");
        check("data04", 32'(data), 32'h04);

        // rx_en dropped mid-frame aborts the partial byte
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx_en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rx_en = 1'b1;
        idle_bits(1);
        send_good(8'h3C);
        drain("rxen_abort");
        check("data3C", 32'(data), 32'h3C);

        // Reset after four data bits
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_rda", 32'(rda), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle_bits(1);
        send_good(8'h53);
        drain("after_rst");
        check("after_rst_data", 32'(data), 32'h53);

        // Stalled device clock after five bits triggers the watchdog
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        ps2_data = 1'b1;
        repeat (TIMEOUT + 100) @(posedge clk);
        #2;
        send_good(8'h04);
        drain("timeout");
        check("timeout_data", 32'(data), 32'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
